// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, frame constants and baud helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam int unsigned UART_BITS_PER_BYTE = 8;
  localparam int unsigned UART_FRAME_BITS    = 10;

  // Clock cycles per UART bit, truncated.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer shared by UART TX/RX.
// Ports:
//   rd_clk  - clock, all logic on posedge
//   reset_n - synchronous active-low reset
//   clear   - restart the bit period (counter to 0 on the next edge)
//   tick    - registered, high on the last cycle of each bit period
module uart_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic rd_clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Tick is precomputed from the next count so it lines up with cnt_q == LAST.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge rd_clk) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_word_tx.sv
// Pops DATA_LEN-bit words from a FIFO and sends them as 8N1 bytes, low byte first.
// Ports:
//   rd_clk       - read-domain clock
//   reset_n      - synchronous active-low reset
//   tx_enable    - allows new words to be popped (sampled in IDLE only)
//   fifo_empty   - FIFO empty flag (sampled in IDLE only)
//   fifo_data    - FIFO registered data_out, valid the cycle after the pop
//   fifo_read_en - one-cycle pop strobe
//   tx           - UART line, idle high
//   busy         - high whenever not IDLE
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned DATA_LEN     = 16,
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE)
) (
  input  logic                rd_clk,
  input  logic                reset_n,
  input  logic                tx_enable,
  input  logic                fifo_empty,
  input  logic [DATA_LEN-1:0] fifo_data,
  output logic                fifo_read_en,
  output logic                tx,
  output logic                busy
);

  localparam int unsigned BYTES  = DATA_LEN / 8;
  localparam int unsigned BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned BIT_W  = $clog2(UART_BITS_PER_BYTE);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(UART_BITS_PER_BYTE - 1);

  if ((DATA_LEN == 0) || ((DATA_LEN % 8) != 0)) begin : g_bad_data_len
    $error("uart_word_tx: DATA_LEN must be a non-zero multiple of 8");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_word_tx: CLKS_PER_BIT must be at least 2");
  end

  uart_tx_state_t      state_q, state_d;
  logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0]   byte_idx_q, byte_idx_d;
  logic [DATA_LEN-1:0] shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                fifo_read_en_q, fifo_read_en_d;
  logic                busy_q, busy_d;
  logic                baud_clear_c;
  logic                baud_tick;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .rd_clk (rd_clk),
    .reset_n(reset_n),
    .clear  (baud_clear_c),
    .tick   (baud_tick)
  );

  // Next state plus outputs; outputs are derived from the next state so the
  // registered versions line up with the state they belong to.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;

    case (state_q)
      IDLE: begin
        if (!fifo_empty && tx_enable) begin
          state_d = POP;
        end
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d    = fifo_data;
        byte_idx_d = '0;
        state_d    = START;
      end
      START: begin
        if (baud_tick) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        // The word shifts right once per data bit, so bit 0 is always on the line.
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (byte_idx_q < LAST_BYTE) begin
            byte_idx_d = byte_idx_q + BYTE_W'(1);
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    baud_clear_c   = (state_d != state_q);
    fifo_read_en_d = (state_d == POP);
    busy_d         = (state_d != IDLE);
    tx_d           = 1'b1;
    if (state_d == START) begin
      tx_d = 1'b0;
    end else if (state_d == DATA) begin
      tx_d = shift_d[0];
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      bit_idx_q      <= '0;
      byte_idx_q     <= '0;
      shift_q        <= '0;
      tx_q           <= 1'b1;
      fifo_read_en_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_idx_q      <= bit_idx_d;
      byte_idx_q     <= byte_idx_d;
      shift_q        <= shift_d;
      tx_q           <= tx_d;
      fifo_read_en_q <= fifo_read_en_d;
      busy_q         <= busy_d;
    end
  end

  assign tx           = tx_q;
  assign fifo_read_en = fifo_read_en_q;
  assign busy         = busy_q;

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
Drains 16-bit words from the read side of the Ethernet-to-UART clock-crossing FIFO and serializes each word onto a UART TX line (8N1, LSB first). It runs entirely in the 50 MHz read-clock domain. It owns the FIFO's read_en and consumes its registered data_out, which arrives one cycle after the pop. Each word is sent as DATA_LEN/8 bytes, low byte first.

Parameters:
CLK_FREQ, 50_000_000, rd_clk frequency in Hz
BAUD_RATE, 115200, UART line rate in bit/s
DATA_LEN, 16, FIFO word width; must be a non-zero multiple of 8 (elaboration error otherwise)
CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (434), rd_clk cycles per UART bit; minimum 2

Ports:
rd_clk  input  1  read-domain clock; all logic on posedge
reset_n  input  1  synchronous, active-low reset
tx_enable  input  1  permits popping new words; does not abort a word in flight
fifo_empty  input  1  FIFO empty flag (read domain)
fifo_data  input  DATA_LEN  FIFO data_out; valid the cycle after fifo_read_en
fifo_read_en  output  1  one-cycle pop strobe to the FIFO
tx  output  1  UART serial line, idle high
busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE, tx=1, fifo_read_en=0, busy=0. Bit, byte and baud counters and the shift register clear to 0.
- Reset mid-frame: tx returns to 1 on that edge. The partial word is discarded and never resent. There is no glitch low after reset.
- All outputs are registered. The FSM is Moore-style. States: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE: tx=1. Moves to POP when fifo_empty==0 && tx_enable==1. Otherwise stays.
- POP: exactly 1 cycle with fifo_read_en=1. Then moves to LOAD. fifo_read_en is never high in any other state.
- LOAD: 1 cycle. Captures fifo_data into the word register and sets byte_idx=0. Then moves to START.
- START: tx=0 for CLKS_PER_BIT cycles. Then DATA with bit_idx=0.
- DATA: tx = current byte[bit_idx], held CLKS_PER_BIT cycles per bit. After bit 7, moves to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then:
  - if byte_idx < DATA_LEN/8-1: increment byte_idx, go to START;
  - else go to IDLE.
- Byte k of the word is fifo_data[8k+7:8k]. Byte 0 is sent first.
- Latency: the first IDLE cycle seeing non-empty is c0. fifo_read_en is high in c1. tx falls at the start of c3.
- Word duration: START to end of final STOP is 10*(DATA_LEN/8)*CLKS_PER_BIT cycles (20*434 = 8680 at defaults).
- Back-to-back words: the last stop bit is followed by IDLE, POP and LOAD, so the line stays high for 3 extra cycles. This is legal 8N1.
- Baud counter: counts 0..CLKS_PER_BIT-1, resets to 0 on every state entry, and is sized $clog2(CLKS_PER_BIT).
- tx_enable: sampled only in IDLE. Deasserting it mid-word lets the word complete.
- fifo_empty: sampled only in IDLE. It cannot re-assert between IDLE and POP, because only this block reads the FIFO.
- busy is high from POP through the final STOP.

Decomposition:
- Shared package uart_pkg:
  - typedef enum logic [2:0] uart_tx_state_t {IDLE, POP, LOAD, START, DATA, STOP};
  - constants UART_BITS_PER_BYTE=8 and UART_FRAME_BITS=10;
  - function clks_per_bit(clk_freq, baud).
- Sub-module uart_baud_counter (params CLKS_PER_BIT; ports rd_clk, reset_n, clear, tick): generates a one-cycle tick on the last cycle of each bit period. It is reused by the future UART RX block.

Test Plan:
- Bench settings: CLKS_PER_BIT=4, DATA_LEN=16. A behavioural FIFO model has 1-cycle registered read latency.
- Single word 0xA55A pushed, tx_enable=1 -> fifo_read_en high for exactly 1 cycle. tx falls 2 cycles later. Line decodes as bytes 0x5A then 0xA5, 8N1, 4 cycles/bit. busy is high for 2+80 cycles.
- FIFO held empty for 200 cycles -> fifo_read_en never asserts, tx=1, busy=0 throughout.
- Three words 0x0001, 0x8000, 0xFFFF queued -> three pops and six bytes 01 00 00 80 FF FF. Each inter-word gap has exactly 3 extra high cycles beyond the stop bit. No pop occurs while busy is high after POP.
- tx_enable dropped mid-way through byte 0 of 0x1234 -> both bytes 0x34 and 0x12 complete, then no further pop while the FIFO still holds data. Re-raising tx_enable pops within 1 cycle.
- reset_n pulsed low for 1 cycle during DATA of byte 1 -> tx=1, busy=0 and fifo_read_en=0 on the next edge. Reset values hold while reset_n=0. The next queued word transmits cleanly afterwards.
- DATA_LEN=8 elaboration with word 0xC3 -> one byte per pop; line shows 0,1,1,0,0,0,0,1,1,1.
